// File: rtl/c4_pkg.sv
// c4_pkg: shared Connect-4 board constants and types.
//   NUM_COLS / NUM_ROWS : board geometry
//   col_t               : one bit per column (one-hot column selects, full flags)
//   turn_state_t        : turn_scheduler FSM states
package c4_pkg;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 6;

  typedef logic [NUM_COLS-1:0] col_t;

  typedef enum logic [3:0] {
    IDLE,
    LOCAL_TURN,
    DROP_LOCAL,
    SEND,
    TX_WAIT,
    REMOTE_TURN,
    DROP_REMOTE,
    DONE,
    ERROR
  } turn_state_t;

endpackage

// File: rtl/col_legal.sv
// col_legal: combinational legality check for a column select.
//   col   in  W  requested column, must be one-hot
//   full  in  W  per-column full flags
//   legal out 1  col is one-hot and its column is not full
module col_legal #(
  parameter int W = c4_pkg::NUM_COLS
) (
  input  logic [W-1:0] col,
  input  logic [W-1:0] full,
  output logic         legal
);

  logic one_hot;

  // Nonzero with a single bit set: clearing the lowest set bit leaves nothing.
  assign one_hot = (col != '0) && ((col & (col - W'(1))) == '0);
  assign legal   = one_hot && ((col & full) == '0);

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences one two-board Connect-4 game.
//   Owns the turn, routes local moves to drop_red and remote moves to drop_green,
//   launches serial_out transmissions and consumes serial_in columns.
// Ports:
//   clk, reset                 clock, async active-high reset
//   local_first                strap, 1 = this board opens
//   enter, column              local move request (column one-hot)
//   col_full                   grid full flags
//   game_over                  win/draw level
//   peer_ready                 remote board can accept a column
//   ready_out                  waiting for a remote column
//   tx_start, tx_col, tx_busy  serial_out handshake
//   rx_valid, rx_col           serial_in result
//   drop_red, drop_green       one-cycle one-hot grid drops
//   p1, p2                     turn indicators (local / remote)
//   error                      sticky protocol error
// Build option: TURN_SCHED_TIMEOUT_EN adds a TIMEOUT_CYC watchdog over SEND+TX_WAIT.
module turn_scheduler #(
  parameter int NUM_COLS    = c4_pkg::NUM_COLS,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                local_first,
  input  logic                enter,
  input  logic [NUM_COLS-1:0] column,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_over,
  input  logic                peer_ready,
  output logic                ready_out,
  output logic                tx_start,
  output logic [NUM_COLS-1:0] tx_col,
  input  logic                tx_busy,
  input  logic                rx_valid,
  input  logic [NUM_COLS-1:0] rx_col,
  output logic [NUM_COLS-1:0] drop_red,
  output logic [NUM_COLS-1:0] drop_green,
  output logic                p1,
  output logic                p2,
  output logic                error
);

  import c4_pkg::*;

  turn_state_t         state, state_n;
  logic                busy_seen, busy_seen_n;
  logic                col_ok, rx_ok;
  logic                set_err;
  logic                timed_out;
  logic [NUM_COLS-1:0] tx_col_n;

  col_legal #(.W(NUM_COLS)) u_col_legal (.col(column), .full(col_full), .legal(col_ok));
  col_legal #(.W(NUM_COLS)) u_rx_legal  (.col(rx_col), .full(col_full), .legal(rx_ok));

`ifdef TURN_SCHED_TIMEOUT_EN
  localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYC - 1);
  logic [25:0] to_cnt;

  assign timed_out = (state == SEND || state == TX_WAIT) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 to_cnt <= '0;
    else if (state_n == SEND && state != SEND) to_cnt <= '0;
    else if (state == SEND || state == TX_WAIT) to_cnt <= to_cnt + 26'd1;
  end
`else
  assign timed_out = 1'b0;
  // Watchdog not built; the limit is only referenced so both builds share one parameter list.
  if (TIMEOUT_CYC < 2) begin : g_timeout_not_built
  end
`endif

  always_comb begin
    state_n     = state;
    busy_seen_n = busy_seen;
    tx_col_n    = tx_col;
    set_err     = 1'b0;
    // A column arriving when none was asked for is a protocol violation, but it does
    // not disturb the sequence; DONE and ERROR simply ignore the port.
    if (rx_valid && !(state inside {REMOTE_TURN, DONE, ERROR})) set_err = 1'b1;
    case (state)
      IDLE:        state_n = local_first ? LOCAL_TURN : REMOTE_TURN;
      LOCAL_TURN: begin
        if (game_over) state_n = DONE;
        else if (enter && col_ok) begin
          state_n  = DROP_LOCAL;
          tx_col_n = column;   // latched with the drop so the sent column matches the piece
        end
      end
      DROP_LOCAL:  state_n = SEND;
      SEND: begin
        busy_seen_n = 1'b0;
        if (game_over) state_n = DONE;
        else if (timed_out) begin
          state_n = ERROR;
          set_err = 1'b1;
        end else if (peer_ready && !tx_busy) state_n = TX_WAIT;
      end
      TX_WAIT: begin
        if (game_over) state_n = DONE;
        else if (timed_out) begin
          state_n = ERROR;
          set_err = 1'b1;
        end else if (busy_seen && !tx_busy) state_n = REMOTE_TURN;
        else if (tx_busy) busy_seen_n = 1'b1;
      end
      REMOTE_TURN: begin
        if (game_over) state_n = DONE;
        else if (rx_valid) begin
          if (rx_ok) state_n = DROP_REMOTE;
          else begin
            state_n = ERROR;
            set_err = 1'b1;
          end
        end
      end
      DROP_REMOTE: state_n = LOCAL_TURN;
      DONE:        state_n = DONE;
      ERROR:       state_n = ERROR;
      default:     state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so each
  // output is valid in the same cycle the state it describes is current.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy_seen  <= 1'b0;
      tx_col     <= '0;
      p1         <= 1'b0;
      p2         <= 1'b0;
      ready_out  <= 1'b0;
      tx_start   <= 1'b0;
      drop_red   <= '0;
      drop_green <= '0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      busy_seen  <= busy_seen_n;
      tx_col     <= tx_col_n;
      p1         <= (state_n == LOCAL_TURN);
      p2         <= (state_n == REMOTE_TURN);
      ready_out  <= (state_n == REMOTE_TURN);
      tx_start   <= (state == SEND) && (state_n == TX_WAIT);
      drop_red   <= (state_n == DROP_LOCAL)  ? column : '0;
      drop_green <= (state_n == DROP_REMOTE) ? rx_col : '0;
      error      <= error | set_err;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: table-driven bench for turn_scheduler with a scoreboard queue.
// Each row drives one cycle of inputs and pushes the outputs expected after the next
// clock edge; the check after that edge pops and compares them.
module tb_turn_scheduler;
  import c4_pkg::*;

  logic clk, reset, local_first, enter, game_over, peer_ready, tx_busy, rx_valid;
  col_t column, col_full, rx_col;
  logic ready_out, tx_start, p1, p2, error;
  col_t tx_col, drop_red, drop_green;

  turn_scheduler #(.NUM_COLS(7), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .local_first(local_first), .enter(enter),
    .column(column), .col_full(col_full), .game_over(game_over),
    .peer_ready(peer_ready), .ready_out(ready_out), .tx_start(tx_start),
    .tx_col(tx_col), .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_col(rx_col),
    .drop_red(drop_red), .drop_green(drop_green), .p1(p1), .p2(p2), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out vector: {p1, p2, ready_out, tx_start, error, tx_col, drop_red, drop_green}
  typedef struct {
    string       name;
    logic [6:0]  ctl;   // {reset, local_first, enter, game_over, peer_ready, tx_busy, rx_valid}
    col_t        col;
    col_t        full;
    col_t        rxc;
    logic [25:0] exp;
  } row_t;

  localparam col_t Z  = 7'b0000000;
  localparam col_t C  = 7'b0000100;
  localparam col_t G  = 7'b0010000;
  localparam col_t H  = 7'b1000000;
  localparam col_t A1 = 7'b0000001;
  localparam col_t B2 = 7'b0000010;

  row_t        tbl[$];
  logic [25:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [25:0] o(logic [4:0] flags, col_t txc, col_t dr, col_t dg);
    return {flags, txc, dr, dg};
  endfunction

  function automatic row_t r(string n, logic [6:0] ctl, col_t c, col_t f, col_t rc, logic [25:0] e);
    row_t t;
    t.name = n; t.ctl = ctl; t.col = c; t.full = f; t.rxc = rc; t.exp = e;
    return t;
  endfunction

  task automatic check(input string name);
    logic [25:0] act, exp;
    act = {p1, p2, ready_out, tx_start, error, tx_col, drop_red, drop_green};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", name, act, exp);
      end
    end
  endtask

  task automatic apply(input row_t v);
    {reset, local_first, enter, game_over, peer_ready, tx_busy, rx_valid} = v.ctl;
    column   = v.col;
    col_full = v.full;
    rx_col   = v.rxc;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    check(v.name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Local opens; illegal enters are ignored, legal one drops and is sent.
    tbl.push_back(r("rstA",            7'b1100100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("idle2local",      7'b0100100, C, Z, Z, o(5'b10000, Z, Z, Z)));
    tbl.push_back(r("enter_multi_hot", 7'b0110100, 7'b0000110, Z, Z, o(5'b10000, Z, Z, Z)));
    tbl.push_back(r("enter_full",      7'b0110100, C, C, Z, o(5'b10000, Z, Z, Z)));
    tbl.push_back(r("no_enter",        7'b0100100, C, Z, Z, o(5'b10000, Z, Z, Z)));
    tbl.push_back(r("enter_ok",        7'b0110000, C, Z, Z, o(5'b00000, C, C, Z)));
    tbl.push_back(r("send_wait",       7'b0100000, C, Z, Z, o(5'b00000, C, Z, Z)));
    tbl.push_back(r("send_hold",       7'b0100000, C, Z, Z, o(5'b00000, C, Z, Z)));
    tbl.push_back(r("tx_start",        7'b0100100, C, Z, Z, o(5'b00010, C, Z, Z)));
    for (int i = 0; i < 8; i++)
      tbl.push_back(r("tx_busy",       7'b0100110, C, Z, Z, o(5'b00000, C, Z, Z)));
    tbl.push_back(r("busy_fall",       7'b0100100, C, Z, Z, o(5'b01100, C, Z, Z)));
    tbl.push_back(r("enter_in_remote", 7'b0110100, A1, Z, Z, o(5'b01100, C, Z, Z)));
    tbl.push_back(r("rx_drop",         7'b0100101, C, Z, G, o(5'b00000, C, Z, G)));
    tbl.push_back(r("after_green",     7'b0100100, C, Z, Z, o(5'b10000, C, Z, Z)));
    // Edge column, SEND waits out a busy shifter, TX_WAIT needs a rise before a fall.
    tbl.push_back(r("enter_edge_col",  7'b0110100, H, Z, Z, o(5'b00000, H, H, Z)));
    tbl.push_back(r("to_send",         7'b0100110, C, Z, Z, o(5'b00000, H, Z, Z)));
    tbl.push_back(r("send_busy",       7'b0100110, C, Z, Z, o(5'b00000, H, Z, Z)));
    tbl.push_back(r("tx_start2",       7'b0100100, C, Z, Z, o(5'b00010, H, Z, Z)));
    tbl.push_back(r("wait_rise",       7'b0100100, C, Z, Z, o(5'b00000, H, Z, Z)));
    tbl.push_back(r("busy_hi",         7'b0100110, C, Z, Z, o(5'b00000, H, Z, Z)));
    tbl.push_back(r("busy_lo",         7'b0100100, C, Z, Z, o(5'b01100, H, Z, Z)));
    tbl.push_back(r("rx_bad",          7'b0100101, C, Z, 7'b0000011, o(5'b00001, H, Z, Z)));
    tbl.push_back(r("rx_in_error",     7'b0100101, C, Z, G, o(5'b00001, H, Z, Z)));
    tbl.push_back(r("enter_in_error",  7'b0110100, C, Z, Z, o(5'b00001, H, Z, Z)));
    // Remote opens; simultaneous enter/rx, stray rx in a DROP state, game_over in SEND.
    tbl.push_back(r("rstB",            7'b1000100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("idle2remote",     7'b0000100, C, Z, Z, o(5'b01100, Z, Z, Z)));
    tbl.push_back(r("rx_and_enter",    7'b0010101, C, Z, A1, o(5'b00000, Z, Z, A1)));
    tbl.push_back(r("rx_in_drop",      7'b0000101, C, Z, B2, o(5'b10001, Z, Z, Z)));
    tbl.push_back(r("enter_B",         7'b0010000, B2, Z, Z, o(5'b00001, B2, B2, Z)));
    tbl.push_back(r("send_B",          7'b0000000, C, Z, Z, o(5'b00001, B2, Z, Z)));
    tbl.push_back(r("go_in_send",      7'b0001000, C, Z, Z, o(5'b00001, B2, Z, Z)));
    tbl.push_back(r("done_ignores",    7'b0011101, C, Z, G, o(5'b00001, B2, Z, Z)));
    tbl.push_back(r("done_holds",      7'b0000100, C, Z, Z, o(5'b00001, B2, Z, Z)));
    // game_over during REMOTE_TURN, then DONE ignores rx and enter without flagging.
    tbl.push_back(r("rstC",            7'b1000100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("idle2remoteC",    7'b0000100, C, Z, Z, o(5'b01100, Z, Z, Z)));
    tbl.push_back(r("go_in_remote",    7'b0001100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("done_rx",         7'b0000101, C, Z, G, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("done_enter",      7'b0010100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("rstD",            7'b1100100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    tbl.push_back(r("idle2localD",     7'b0100100, C, Z, Z, o(5'b10000, Z, Z, Z)));
`ifdef TURN_SCHED_TIMEOUT_EN
    // peer never ready: error 16 cycles after SEND entry.
    tbl.push_back(r("enter_to",        7'b0110000, C, Z, Z, o(5'b00000, C, C, Z)));
    tbl.push_back(r("to_send_entry",   7'b0100000, C, Z, Z, o(5'b00000, C, Z, Z)));
    for (int i = 0; i < 15; i++)
      tbl.push_back(r("to_counting",   7'b0100000, C, Z, Z, o(5'b00000, C, Z, Z)));
    tbl.push_back(r("timeout",         7'b0100000, C, Z, Z, o(5'b00001, C, Z, Z)));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset in the middle of a shift clears outputs immediately and abandons the shift.
    apply(r("rstE",        7'b1100100, C, Z, Z, o(5'b00000, Z, Z, Z)));
    apply(r("idle2localE", 7'b0100100, C, Z, Z, o(5'b10000, Z, Z, Z)));
    apply(r("enterE",      7'b0110100, C, Z, Z, o(5'b00000, C, C, Z)));
    apply(r("sendE",       7'b0100100, C, Z, Z, o(5'b00000, C, Z, Z)));
    apply(r("tx_startE",   7'b0100100, C, Z, Z, o(5'b00010, C, Z, Z)));
    apply(r("shiftingE",   7'b0100110, C, Z, Z, o(5'b00000, C, Z, Z)));
    #2;
    reset = 1'b1;
    sb.push_back(o(5'b00000, Z, Z, Z));
    #1;
    check("reset_async");
    apply(r("reset_hold",  7'b1100110, C, Z, Z, o(5'b00000, Z, Z, Z)));
    apply(r("after_abort", 7'b0100110, C, Z, Z, o(5'b10000, Z, Z, Z)));
    apply(r("enter_after", 7'b0110110, C, Z, Z, o(5'b00000, C, C, Z)));
    apply(r("send_busyE",  7'b0100110, C, Z, Z, o(5'b00000, C, Z, Z)));
    apply(r("send_holdE",  7'b0100110, C, Z, Z, o(5'b00000, C, Z, Z)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
